// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave controller slice.
package microwave_pkg;

    localparam int unsigned BCD_W = 4;

    // Largest value a digit reaches when it borrows: decimal digits and seconds-tens.
    localparam logic [BCD_W-1:0] DIGIT_MAX_DEC  = 4'd9;
    localparam logic [BCD_W-1:0] DIGIT_MAX_SEXT = 4'd5;

    typedef logic [BCD_W-1:0] bcd_t;

    // Controller state encoding.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_COOK  = 2'd1;
    localparam state_t ST_PAUSE = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    // Index of the set bit in a one-hot keypad vector (caller guarantees one-hot).
    function automatic bcd_t key_to_bcd(input logic [9:0] key);
        bcd_t r;
        r = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (key[i]) r = bcd_t'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/microwave_ctrl_p_bcd_down_counter.sv
// N-digit BCD time register: keypad shift-in, mm:ss down-count, zero detect.
module bcd_down_counter
    import microwave_pkg::*;
#(
    parameter int unsigned N_DIGITS = 3
) (
    input  logic                      clock,
    input  logic                      clearn,
    input  logic                      clear,
    input  logic                      load_en,
    input  bcd_t                      load_digit,
    input  logic                      dec_en,
    output logic [BCD_W*N_DIGITS-1:0] digits,
    output logic                      is_zero,
    output logic                      dec_hits_zero
);

    bcd_t dig_q [N_DIGITS];
    bcd_t dig_d [N_DIGITS];
    logic borrow;

    // Next digit values: clear, shift-in of a new key, or one-second decrement.
    always_comb begin
        borrow = 1'b0;
        for (int unsigned i = 0; i < N_DIGITS; i++) dig_d[i] = dig_q[i];
        if (clear) begin
            for (int unsigned i = 0; i < N_DIGITS; i++) dig_d[i] = '0;
        end else if (load_en) begin
            dig_d[0] = load_digit;
            for (int unsigned i = 1; i < N_DIGITS; i++) dig_d[i] = dig_q[i-1];
        end else if (dec_en && !is_zero) begin
            // Borrow ripples up from the seconds-ones digit; seconds-tens wraps to 5.
            borrow = 1'b1;
            for (int unsigned i = 0; i < N_DIGITS; i++) begin
                if (borrow) begin
                    if (dig_q[i] == '0) begin
                        dig_d[i] = (i == 1) ? DIGIT_MAX_SEXT : DIGIT_MAX_DEC;
                    end else begin
                        dig_d[i] = dig_q[i] - 4'd1;
                        borrow   = 1'b0;
                    end
                end
            end
        end
    end

    // Flatten digits and detect zero / the last remaining second.
    always_comb begin
        digits        = '0;
        is_zero       = 1'b1;
        dec_hits_zero = (dig_q[0] == 4'd1);
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            digits[i*BCD_W +: BCD_W] = dig_q[i];
            if (dig_q[i] != '0) is_zero = 1'b0;
            if (i != 0 && dig_q[i] != '0) dec_hits_zero = 1'b0;
        end
    end

    // Digit registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!clearn) begin
            for (int unsigned i = 0; i < N_DIGITS; i++) dig_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < N_DIGITS; i++) dig_q[i] <= dig_d[i];
        end
    end

endmodule

// File: rtl/microwave_ctrl_p.sv
// Microwave controller top: button edge detect, cook FSM, tick prescaler,
// power duty window and end-of-cook beep timer around the BCD time register.
module microwave_ctrl_p
    import microwave_pkg::*;
#(
    parameter int unsigned N_DIGITS     = 3,
    parameter int unsigned TICK_DIV     = 50,
    parameter int unsigned POWER_LEVELS = 5,
    parameter int unsigned BEEP_CYCLES  = 100
) (
    input  logic                               clock,
    input  logic                               clearn,
    input  logic                               startn,
    input  logic                               stopn,
    input  logic                               door_closed,
    input  logic [9:0]                         keypad,
    input  logic                               power_key,
    output logic [4*N_DIGITS-1:0]              digits_bcd,
    output logic [$clog2(POWER_LEVELS+1)-1:0]  power_level,
    output logic                               mag_on,
    output logic                               running,
    output logic                               paused,
    output logic                               done_beep
);

    localparam int unsigned PW  = $clog2(POWER_LEVELS + 1);
    localparam int unsigned PSW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned BW  = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;

    localparam logic [PSW-1:0] PRE_LAST  = PSW'(TICK_DIV - 1);
    localparam logic [PW-1:0]  WIN_LAST  = PW'(POWER_LEVELS - 1);
    localparam logic [PW-1:0]  LVL_MAX   = PW'(POWER_LEVELS);
    localparam logic [BW-1:0]  BEEP_LAST = BW'(BEEP_CYCLES - 1);

    state_t         state_q, state_d;
    logic [PSW-1:0] pre_q, pre_d;
    logic [PW-1:0]  win_q, win_d;
    logic [PW-1:0]  power_q, power_d;
    logic [BW-1:0]  beep_q, beep_d;

    logic       start_prev_q, stop_prev_q, power_prev_q;
    logic [9:0] keypad_prev_q;

    logic       start_edge, stop_edge, power_edge, key_valid;
    logic [9:0] key_rise;

    logic cnt_clear, cnt_load, cnt_dec;
    logic is_zero, dec_hits_zero;

    bcd_down_counter #(
        .N_DIGITS(N_DIGITS)
    ) u_time (
        .clock        (clock),
        .clearn       (clearn),
        .clear        (cnt_clear),
        .load_en      (cnt_load),
        .load_digit   (key_to_bcd(keypad)),
        .dec_en       (cnt_dec),
        .digits       (digits_bcd),
        .is_zero      (is_zero),
        .dec_hits_zero(dec_hits_zero)
    );

    // Edges against the one-cycle-old copy; a key counts only if it alone is pressed.
    always_comb begin
        start_edge = ~startn & start_prev_q;
        stop_edge  = ~stopn & stop_prev_q;
        power_edge = power_key & ~power_prev_q;
        key_rise   = keypad & ~keypad_prev_q;
        key_valid  = $onehot(key_rise) && $onehot(keypad);
    end

    // Cook FSM with door > stop > start priority, prescaler, duty window and beep timer.
    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q;
        win_d     = win_q;
        power_d   = power_q;
        beep_d    = beep_q;
        cnt_clear = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_load = key_valid;
                if (power_edge) power_d = (power_q == LVL_MAX) ? PW'(1) : power_q + PW'(1);
                if (start_edge && door_closed && !is_zero) begin
                    state_d = ST_COOK;
                    pre_d   = '0;
                    win_d   = '0;
                end
            end
            ST_COOK: begin
                if (!door_closed || stop_edge) begin
                    state_d = ST_PAUSE;
                end else if (pre_q == PRE_LAST) begin
                    pre_d   = '0;
                    win_d   = (win_q == WIN_LAST) ? '0 : win_q + PW'(1);
                    cnt_dec = 1'b1;
                    if (dec_hits_zero) begin
                        state_d = ST_DONE;
                        beep_d  = '0;
                    end
                end else begin
                    pre_d = pre_q + PSW'(1);
                end
            end
            ST_PAUSE: begin
                if (stop_edge) begin
                    state_d   = ST_IDLE;
                    cnt_clear = 1'b1;
                end else if (start_edge && door_closed) begin
                    state_d = ST_COOK;
                end
            end
            ST_DONE: begin
                if (stop_edge || beep_q == BEEP_LAST) state_d = ST_IDLE;
                else beep_d = beep_q + BW'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and edge-detect registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!clearn) begin
            state_q       <= ST_IDLE;
            pre_q         <= '0;
            win_q         <= '0;
            power_q       <= LVL_MAX;
            beep_q        <= '0;
            start_prev_q  <= 1'b1;
            stop_prev_q   <= 1'b1;
            power_prev_q  <= 1'b0;
            keypad_prev_q <= '0;
        end else begin
            state_q       <= state_d;
            pre_q         <= pre_d;
            win_q         <= win_d;
            power_q       <= power_d;
            beep_q        <= beep_d;
            start_prev_q  <= startn;
            stop_prev_q   <= stopn;
            power_prev_q  <= power_key;
            keypad_prev_q <= keypad;
        end
    end

    // Outputs; door gating of the magnetron is combinational.
    always_comb begin
        power_level = power_q;
        running     = (state_q == ST_COOK);
        paused      = (state_q == ST_PAUSE);
        done_beep   = (state_q == ST_DONE);
        mag_on      = running && door_closed && (win_q < power_q);
    end

endmodule

// File: tb/tb_microwave_ctrl_p.sv
// Self-checking bench for microwave_ctrl_p: directed vector table, multi-cycle
// scenarios and random stimulus against a time-value reference model.
module tb_microwave_ctrl_p;

    localparam int ND = 3;
    localparam int TD = 4;
    localparam int PL = 5;
    localparam int BC = 10;

    localparam int M_IDLE  = 0;
    localparam int M_COOK  = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic        clock = 1'b0;
    logic        clearn, startn, stopn, door_closed, power_key;
    logic [9:0]  keypad;
    logic [11:0] digits_bcd;
    logic [2:0]  power_level;
    logic        mag_on, running, paused, done_beep;

    always #5 clock = ~clock;

    microwave_ctrl_p #(
        .N_DIGITS    (ND),
        .TICK_DIV    (TD),
        .POWER_LEVELS(PL),
        .BEEP_CYCLES (BC)
    ) dut (
        .clock      (clock),
        .clearn     (clearn),
        .startn     (startn),
        .stopn      (stopn),
        .door_closed(door_closed),
        .keypad     (keypad),
        .power_key  (power_key),
        .digits_bcd (digits_bcd),
        .power_level(power_level),
        .mag_on     (mag_on),
        .running    (running),
        .paused     (paused),
        .done_beep  (done_beep)
    );

    int vec_cnt  = 0;
    int miss_cnt = 0;

    // Reference model: displayed time held as the decimal number mmss.
    int m_state, m_time, m_sub, m_win, m_lvl, m_beep;
    logic p_start, p_stop, p_pwr;
    logic [9:0] p_kp;

    function automatic int dec_time(input int t);
        return (t % 100 == 0) ? t - 41 : t - 1;
    endfunction

    function automatic int to_bcd(input int t);
        return ((t / 100) % 10) * 256 + ((t / 10) % 10) * 16 + (t % 10);
    endfunction

    task automatic model_clk();
        logic se, te, pe;
        int   ones, rises, digit, old_time;
        if (!clearn) begin
            m_state = M_IDLE; m_time = 0; m_sub = 0; m_win = 0; m_lvl = PL; m_beep = 0;
            p_start = 1'b1; p_stop = 1'b1; p_pwr = 1'b0; p_kp = '0;
            return;
        end
        se = !startn && p_start;
        te = !stopn && p_stop;
        pe = power_key && !p_pwr;
        ones = 0; rises = 0; digit = 0;
        for (int i = 0; i < 10; i++) begin
            if (keypad[i]) begin ones++; digit = i; end
            if (keypad[i] && !p_kp[i]) rises++;
        end
        case (m_state)
            M_IDLE: begin
                old_time = m_time;
                if (ones == 1 && rises == 1) m_time = (m_time * 10 + digit) % 1000;
                if (pe) m_lvl = (m_lvl == PL) ? 1 : m_lvl + 1;
                if (se && door_closed && old_time != 0) begin
                    m_state = M_COOK; m_sub = 0; m_win = 0;
                end
            end
            M_COOK: begin
                if (!door_closed || te) m_state = M_PAUSE;
                else if (m_sub == TD - 1) begin
                    m_sub = 0;
                    m_win = (m_win + 1) % PL;
                    m_time = dec_time(m_time);
                    if (m_time == 0) begin m_state = M_DONE; m_beep = 0; end
                end else m_sub++;
            end
            M_PAUSE: begin
                if (te) begin m_state = M_IDLE; m_time = 0; end
                else if (se && door_closed) m_state = M_COOK;
            end
            default: begin
                if (te || m_beep == BC - 1) m_state = M_IDLE;
                else m_beep++;
            end
        endcase
        p_start = startn; p_stop = stopn; p_pwr = power_key; p_kp = keypad;
    endtask

    task automatic check(input string name, input int act, input int exp);
        vec_cnt++;
        if (act != exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check("digits",  int'(digits_bcd),  to_bcd(m_time));
        check("level",   int'(power_level), m_lvl);
        check("running", int'(running),     int'(m_state == M_COOK));
        check("paused",  int'(paused),      int'(m_state == M_PAUSE));
        check("beep",    int'(done_beep),   int'(m_state == M_DONE));
        check("mag_on",  int'(mag_on),
              int'(m_state == M_COOK && door_closed && m_win < m_lvl));
    endtask

    // One clock: DUT and model both sample the held inputs; outputs compared 1 time unit later.
    task automatic step();
        @(posedge clock);
        model_clk();
        #1;
        check_model();
    endtask

    task automatic idle_inputs();
        clearn = 1'b1; startn = 1'b1; stopn = 1'b1; door_closed = 1'b1;
        keypad = '0; power_key = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        clearn = 1'b0; step();
        clearn = 1'b1; step();
    endtask

    task automatic press_key(input int d);
        keypad = 10'd1 << d; step();
        keypad = '0;         step();
    endtask

    typedef struct {
        logic        cl, st, sp, dr;
        logic [9:0]  kp;
        logic        pk;
        logic [11:0] e_dig;
        int          e_lvl;
        logic        e_run, e_pau, e_mag;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int run_cnt, beep_cnt, cyc, r;
        logic [11:0] frozen;

        // cl st sp dr  keypad  pk  digits lvl run pau mag
        tbl.push_back('{0, 1, 1, 1, 10'b0000000000, 0, 12'h000, 5, 0, 0, 0});
        tbl.push_back('{1, 1, 1, 1, 10'b0000000011, 0, 12'h000, 5, 0, 0, 0});
        tbl.push_back('{1, 1, 1, 1, 10'b0000000000, 0, 12'h000, 5, 0, 0, 0});
        tbl.push_back('{1, 1, 1, 1, 10'b0000000010, 0, 12'h001, 5, 0, 0, 0});
        tbl.push_back('{1, 1, 1, 1, 10'b0000000000, 0, 12'h001, 5, 0, 0, 0});
        tbl.push_back('{1, 1, 1, 1, 10'b0000001000, 0, 12'h013, 5, 0, 0, 0});
        tbl.push_back('{1, 1, 1, 1, 10'b0000000000, 0, 12'h013, 5, 0, 0, 0});
        tbl.push_back('{1, 1, 1, 1, 10'b0000000001, 0, 12'h130, 5, 0, 0, 0});
        tbl.push_back('{1, 1, 1, 1, 10'b0000000000, 0, 12'h130, 5, 0, 0, 0});
        tbl.push_back('{1, 1, 1, 1, 10'b0000000000, 1, 12'h130, 1, 0, 0, 0});
        tbl.push_back('{1, 1, 1, 1, 10'b0000000000, 0, 12'h130, 1, 0, 0, 0});
        tbl.push_back('{1, 1, 1, 1, 10'b0000000000, 1, 12'h130, 2, 0, 0, 0});
        tbl.push_back('{1, 1, 1, 1, 10'b0000000000, 0, 12'h130, 2, 0, 0, 0});
        tbl.push_back('{1, 0, 1, 0, 10'b0000000000, 0, 12'h130, 2, 0, 0, 0});
        tbl.push_back('{1, 1, 1, 1, 10'b0000000000, 0, 12'h130, 2, 0, 0, 0});
        tbl.push_back('{1, 0, 1, 1, 10'b0000000000, 0, 12'h130, 2, 1, 0, 1});
        tbl.push_back('{1, 1, 1, 1, 10'b0000000000, 0, 12'h130, 2, 1, 0, 1});
        tbl.push_back('{1, 1, 0, 1, 10'b0000000000, 0, 12'h130, 2, 0, 1, 0});
        tbl.push_back('{1, 1, 1, 1, 10'b0000000000, 0, 12'h130, 2, 0, 1, 0});
        tbl.push_back('{1, 1, 0, 1, 10'b0000000000, 0, 12'h000, 2, 0, 0, 0});
        tbl.push_back('{1, 1, 1, 1, 10'b0000000000, 0, 12'h000, 2, 0, 0, 0});
        tbl.push_back('{1, 0, 1, 1, 10'b0000000000, 0, 12'h000, 2, 0, 0, 0});
        tbl.push_back('{1, 1, 1, 1, 10'b0000000000, 0, 12'h000, 2, 0, 0, 0});

        idle_inputs();
        foreach (tbl[i]) begin
            clearn = tbl[i].cl; startn = tbl[i].st; stopn = tbl[i].sp;
            door_closed = tbl[i].dr; keypad = tbl[i].kp; power_key = tbl[i].pk;
            step();
            check("tbl_digits",  int'(digits_bcd),  int'(tbl[i].e_dig));
            check("tbl_level",   int'(power_level), tbl[i].e_lvl);
            check("tbl_running", int'(running),     int'(tbl[i].e_run));
            check("tbl_paused",  int'(paused),      int'(tbl[i].e_pau));
            check("tbl_mag",     int'(mag_on),      int'(tbl[i].e_mag));
        end

        // 1:30 full countdown, then beep length.
        do_reset();
        press_key(1); press_key(3); press_key(0);
        startn = 1'b0; step(); startn = 1'b1;
        check("t1_start_digits", int'(digits_bcd), 'h130);
        for (int k = 0; k < TD; k++) step();
        check("t1_first_tick", int'(digits_bcd), 'h129);
        run_cnt = TD + 1; cyc = 0;
        while (running && cyc < 1000) begin run_cnt++; step(); cyc++; end
        check("t1_cook_cycles", run_cnt - 1, 90 * TD);
        beep_cnt = 0;
        while (done_beep && cyc < 2000) begin beep_cnt++; step(); cyc++; end
        check("t1_beep_cycles", beep_cnt, BC);
        check("t1_end_digits", int'(digits_bcd), 0);

        // 1:00 borrows through seconds-tens to 0:59.
        do_reset();
        press_key(1); press_key(0); press_key(0);
        startn = 1'b0; step(); startn = 1'b1;
        for (int k = 0; k < TD; k++) step();
        check("t2_borrow", int'(digits_bcd), 'h059);

        // Level 3 over a 10 s cook: on for window ticks 0-2, off 3-4.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            power_key = 1'b1; step(); power_key = 1'b0; step();
        end
        check("t3_level", int'(power_level), 3);
        press_key(1); press_key(0);
        startn = 1'b0; step(); startn = 1'b1;
        for (int k = 0; k < 10 * TD; k++) begin
            check("t3_mag_pattern", int'(mag_on), int'(((k / TD) % PL) < 3));
            step();
        end
        check("t3_done", int'(done_beep), 1);

        // Door opened mid-cook: immediate mag drop, pause, frozen digits, resume.
        do_reset();
        press_key(8);
        startn = 1'b0; step(); startn = 1'b1;
        for (int k = 0; k < 5; k++) step();
        door_closed = 1'b0; #1;
        check("t4_mag_door", int'(mag_on), 0);
        step();
        check("t4_paused", int'(paused), 1);
        frozen = digits_bcd;
        for (int k = 0; k < 6; k++) step();
        check("t4_frozen", int'(digits_bcd), int'(frozen));
        door_closed = 1'b1; startn = 1'b0; step(); startn = 1'b1;
        run_cnt = 0; cyc = 0;
        while (running && cyc < 200) begin run_cnt++; step(); cyc++; end
        check("t4_resume_cycles", run_cnt, 8 * TD - 5);

        // Clear mid-cook returns every output to reset values.
        do_reset();
        power_key = 1'b1; step(); power_key = 1'b0; step();
        press_key(5);
        startn = 1'b0; step(); startn = 1'b1;
        step(); step();
        clearn = 1'b0; step(); clearn = 1'b1;
        check("t6_clr_digits", int'(digits_bcd), 0);
        check("t6_clr_level", int'(power_level), PL);
        check("t6_clr_running", int'(running), 0);
        check("t6_clr_mag", int'(mag_on), 0);

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            clearn      = ($urandom_range(0, 299) != 0);
            startn      = ($urandom_range(0, 9) != 0);
            stopn       = ($urandom_range(0, 39) != 0);
            door_closed = ($urandom_range(0, 29) != 0);
            power_key   = ($urandom_range(0, 9) == 0);
            r = int'($urandom_range(0, 9));
            if (r < 6) keypad = '0;
            else if (r < 9) keypad = 10'd1 << $urandom_range(0, 9);
            else keypad = (10'd1 << $urandom_range(0, 9)) | (10'd1 << $urandom_range(0, 9));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
